// File: rtl/router_switch_20_pkg.sv
// Shared constants and XY route helper for the node (2,0) switch stage.
package router_switch_20_pkg;

  localparam int P_N       = 0;
  localparam int P_E       = 1;
  localparam int P_L       = 2;
  localparam int NUM_PORTS = 3;

  // Default flit layout: dest_x in the top COORD_W bits, dest_y just below.
  localparam int DEST_X_MSB = 39;
  localparam int DEST_Y_MSB = 37;

  // Returns the output port index for a destination seen from this node.
  function automatic logic [1:0] route_xy(input int dest_x, input int dest_y,
                                          input int local_x, input int local_y);
    if (dest_x != local_x)
      return 2'(P_E);
    else if (dest_y != local_y)
      return 2'(P_N);
    else
      return 2'(P_L);
  endfunction

endpackage

// File: rtl/router_switch_20_rr_arbiter_3.sv
// Three-way round-robin arbiter; the pointer moves past the last winner.
import router_switch_20_pkg::*;

module rr_arbiter_3 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [2:0] i_req,
  input  logic       i_en,
  output logic [2:0] o_gnt
);

  logic [1:0] r_ptr;
  logic [1:0] w_ptr_nxt;
  logic [2:0] w_sum;
  logic [1:0] w_idx;
  logic       w_found;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_sum = {1'b0, r_ptr} + 3'(k);
      w_idx = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[1:0];
      if (i_en && !w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

  always_comb begin
    w_ptr_nxt = r_ptr;
    if (o_gnt[0])      w_ptr_nxt = 2'd1;
    else if (o_gnt[1]) w_ptr_nxt = 2'd2;
    else if (o_gnt[2]) w_ptr_nxt = 2'd0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_ptr <= 2'd0;
    else       r_ptr <= w_ptr_nxt;
  end

endmodule

// File: rtl/router_switch_20.sv
// Switch stage of node (2,0): XY route, per-output round-robin, one-entry output slots.
import router_switch_20_pkg::*;

module router_switch_20 #(
  parameter int DATASIZE = DEST_X_MSB + 1,
  parameter int LOCAL_X  = 2,
  parameter int LOCAL_Y  = 0,
  parameter int COORD_W  = DEST_X_MSB - DEST_Y_MSB
) (
  input  logic                fifo_clk,
  input  logic                rst,
  input  logic [DATASIZE-1:0] N_data_in,
  input  logic [DATASIZE-1:0] E_data_in,
  input  logic [DATASIZE-1:0] L_data_in,
  input  logic                N_valid_in,
  input  logic                E_valid_in,
  input  logic                L_valid_in,
  output logic                fifo_ready_N,
  output logic                fifo_ready_E,
  output logic                fifo_ready_L,
  output logic [DATASIZE-1:0] N_data_out,
  output logic [DATASIZE-1:0] E_data_out,
  output logic [DATASIZE-1:0] L_data_out,
  output logic                N_valid_out,
  output logic                E_valid_out,
  output logic                L_valid_out,
  input  logic                N_full_in,
  input  logic                E_full_in,
  input  logic                L_full_in
);

  logic [DATASIZE-1:0]  w_din   [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_vin;
  logic [NUM_PORTS-1:0] w_full;
  logic [1:0]           w_route [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_req   [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_gnt   [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_en;
  logic [NUM_PORTS-1:0] w_vout;
  logic [NUM_PORTS-1:0] w_pop;
  logic [DATASIZE-1:0]  w_sel   [NUM_PORTS];

  logic [NUM_PORTS-1:0] r_occ;
  logic [DATASIZE-1:0]  r_data  [NUM_PORTS];

  assign w_din[P_N] = N_data_in;
  assign w_din[P_E] = E_data_in;
  assign w_din[P_L] = L_data_in;
  assign w_vin      = {L_valid_in, E_valid_in, N_valid_in};
  assign w_full     = {L_full_in, E_full_in, N_full_in};

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_route[i] = route_xy(int'(w_din[i][DATASIZE-1 -: COORD_W]),
                            int'(w_din[i][DATASIZE-1-COORD_W -: COORD_W]),
                            LOCAL_X, LOCAL_Y);
    end
  end

  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      w_req[o] = '0;
      for (int i = 0; i < NUM_PORTS; i++)
        w_req[o][i] = w_vin[i] && (w_route[i] == 2'(o));
    end
  end

  // Reset gates both strobes so nothing leaks out while rst is high.
  assign w_vout = r_occ & ~w_full & {NUM_PORTS{~rst}};
  assign w_en   = (~r_occ | w_vout) & {NUM_PORTS{~rst}};

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
    rr_arbiter_3 u_arb (
      .i_clk (fifo_clk),
      .i_rst (rst),
      .i_req (w_req[o]),
      .i_en  (w_en[o]),
      .o_gnt (w_gnt[o])
    );
  end

  always_comb begin
    w_pop = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      w_sel[o] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_gnt[o][i]) begin
          w_sel[o] = w_din[i];
          w_pop[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge fifo_clk or posedge rst) begin
    if (rst) begin
      r_occ <= '0;
      for (int o = 0; o < NUM_PORTS; o++) r_data[o] <= '0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (|w_gnt[o]) begin
          r_occ[o]  <= 1'b1;
          r_data[o] <= w_sel[o];
        end else if (w_vout[o]) begin
          r_occ[o] <= 1'b0;
        end
      end
    end
  end

  assign fifo_ready_N = w_pop[P_N];
  assign fifo_ready_E = w_pop[P_E];
  assign fifo_ready_L = w_pop[P_L];
  assign N_valid_out  = w_vout[P_N];
  assign E_valid_out  = w_vout[P_E];
  assign L_valid_out  = w_vout[P_L];
  assign N_data_out   = r_data[P_N];
  assign E_data_out   = r_data[P_E];
  assign L_data_out   = r_data[P_L];

endmodule
